// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default RX FIFO depth, byte type.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO-to-consumer signal bundle.
// Optional almost_full output is present when UART_RX_FIFO_ALMOST_EN is defined.
// master: the FIFO side; slave: the receiver/consumer side.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  uart_byte_t       rx_data;
  logic             rx_done;
  uart_byte_t       m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overrun;
  logic             ovr_clr;
`ifdef UART_RX_FIFO_ALMOST_EN
  logic             almost_full;
`endif

  modport master (
    input  rx_data, rx_done, m_ready, ovr_clr,
    output m_data, m_valid, count, full, empty, overrun
`ifdef UART_RX_FIFO_ALMOST_EN
    , output almost_full
`endif
  );

  modport slave (
    output rx_data, rx_done, m_ready, ovr_clr,
    input  m_data, m_valid, count, full, empty, overrun
`ifdef UART_RX_FIFO_ALMOST_EN
    , input almost_full
`endif
  );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: edge-detected write from the receiver's done strobe,
// first-word-fall-through valid/ready read side, fill level and sticky overrun.
// Define UART_RX_FIFO_ALMOST_EN to add AF_LEVEL and a registered almost_full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = UART_RX_FIFO_DEPTH,
  parameter int unsigned DATA_W   = UART_DATA_W
`ifdef UART_RX_FIFO_ALMOST_EN
  , parameter int unsigned AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.master bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt_c;
  logic [PTR_W-1:0]  rd_ptr_nxt_c;
  logic              rx_done_d;
  logic              armed;
  logic              overrun;
  logic              push_c;
  logic              pop_c;
  logic              wr_en_c;
  logic              full_c;
  logic              empty_c;
  logic [DATA_W-1:0] ram_rdata;

  // Storage
  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (DATA_W'(bus.rx_data)),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Occupancy flags from pointer comparison
  always_comb begin
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  end

  // Handshake decode and next pointers; a strobe still high when reset
  // releases is ignored because armed holds the first post-reset edge off.
  always_comb begin
    push_c       = bus.rx_done && !rx_done_d && armed;
    pop_c        = !empty_c && bus.m_ready;
    wr_en_c      = push_c && (!full_c || pop_c);
    wr_ptr_nxt_c = wr_en_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nxt_c = pop_c   ? rd_ptr + PTR_W'(1) : rd_ptr;
  end

  // Pointer, edge-detector and overrun registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rx_done_d <= 1'b0;
      armed     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt_c;
      rd_ptr    <= rd_ptr_nxt_c;
      rx_done_d <= bus.rx_done;
      armed     <= 1'b1;
      if (push_c && full_c && !pop_c) begin
        overrun <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_ALMOST_EN
  logic [PTR_W-1:0] count_nxt_c;
  logic             almost_full;

  assign count_nxt_c = wr_ptr_nxt_c - rd_ptr_nxt_c;

  // Registered threshold flag reflecting the post-edge fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt_c >= PTR_W'(AF_LEVEL));
    end
  end

  assign bus.almost_full = almost_full;
`endif

  assign bus.m_data  = empty_c ? '0 : uart_byte_t'(ram_rdata);
  assign bus.m_valid = !empty_c;
  assign bus.count   = wr_ptr - rd_ptr;
  assign bus.full    = full_c;
  assign bus.empty   = empty_c;
  assign bus.overrun = overrun;

endmodule : uart_rx_fifo
